// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator: channel mode, config record,
// default counter width and the channel-index width helper.
package pulse_gen_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } pg_mode_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] width;
        pg_mode_e             mode;
    } pg_cfg_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse generator channel: period counter, active/shadow configuration,
// pending-update flag and the registered out/done strobes.
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned RST_PERIOD = 2,
    parameter int unsigned RST_WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_width,
    input  logic             i_oneshot,
    output logic             o_pending,
    output logic             o_out,
    output logic             o_done
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] width;
        pg_mode_e         mode;
    } ch_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } ch_state_e;

    ch_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    ch_cfg_t          r_act, r_shd, w_act_nxt, w_shd_nxt, w_new;
    logic             r_pend, w_pend_nxt;
    logic             r_out, w_out_nxt;
    logic             r_done, w_done_nxt;
    logic             w_wrap, w_mid, w_defer, w_commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_act   <= '{period: CNT_W'(RST_PERIOD), width: CNT_W'(RST_WIDTH), mode: MODE_CONT};
            r_shd   <= '0;
            r_pend  <= 1'b0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_act   <= w_act_nxt;
            r_shd   <= w_shd_nxt;
            r_pend  <= w_pend_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_new    = '{period: i_period, width: i_width,
                     mode: i_oneshot ? MODE_ONESHOT : MODE_CONT};
        w_wrap   = (r_state == ST_RUN) && i_en && (r_cnt == r_act.period);
        w_mid    = (r_state == ST_RUN) && i_en && !w_wrap;
        w_defer  = i_wr && w_mid;
        // Shadow is also flushed when the channel goes idle, so a stopped channel never blocks writes.
        w_commit = r_pend && (w_wrap || !i_en);

        w_act_nxt = r_act;
        if (w_commit) begin
            w_act_nxt = r_shd;
        end else if (i_wr && !w_mid) begin
            w_act_nxt = w_new;
        end
        w_shd_nxt  = w_defer ? w_new : r_shd;
        w_pend_nxt = w_defer || (r_pend && !w_commit);

        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_out_nxt   = (w_act_nxt.width != '0);
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        if (r_act.mode == MODE_ONESHOT) begin
                            w_state_nxt = ST_FIN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_out_nxt = (w_act_nxt.width != '0);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_out_nxt = (w_cnt_nxt < w_act_nxt.width);
                    end
                end
                ST_FIN:  w_state_nxt = ST_FIN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_pending = r_pend;
    assign o_out     = r_out;
    assign o_done    = r_done;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable periodic pulse generator: per-channel instances plus
// the shared configuration write port (channel decode and ready mux).
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned RST_PERIOD = 2,
    parameter int unsigned RST_WIDTH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             en,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]              cfg_period,
    input  logic [CNT_W-1:0]              cfg_width,
    input  logic                          cfg_oneshot,
    output logic [NUM_CH-1:0]             out,
    output logic [NUM_CH-1:0]             done
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0]      w_pend;
    logic [NUM_CH-1:0]      w_wr;
    logic [(1<<CH_W)-1:0]   w_pend_x;

    // Indices beyond NUM_CH read as not pending; writes to them match no channel.
    always_comb begin
        w_pend_x             = '0;
        w_pend_x[NUM_CH-1:0] = w_pend;
    end

    assign cfg_ready = ~w_pend_x[cfg_ch];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_wr[c] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(c));

        pulse_gen_channel #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD),
            .RST_WIDTH  (RST_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en[c]),
            .i_wr      (w_wr[c]),
            .i_period  (cfg_period),
            .i_width   (cfg_width),
            .i_oneshot (cfg_oneshot),
            .o_pending (w_pend[c]),
            .o_out     (out[c]),
            .o_done    (done[c])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: per-cycle comparison against a
// period-position model, plus hand-computed waveform expectations.
module tb_pulse_gen_multi;
    import pulse_gen_pkg::*;

    localparam int NCH     = 4;
    localparam int PH_IDLE = -1;
    localparam int PH_FIN  = -2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_valid, cfg_ready, cfg_oneshot;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period, cfg_width;
    logic [3:0]  out, done;

    int n_cmp = 0;
    int n_bad = 0;

    pg_cfg_t    m_act[NCH];
    pg_cfg_t    m_shd[NCH];
    bit         m_pend[NCH];
    int         m_ph[NCH];
    logic [3:0] m_out, m_done;

    pulse_gen_multi #(.NUM_CH(4), .CNT_W(16), .RST_PERIOD(2), .RST_WIDTH(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_oneshot(cfg_oneshot),
        .out(out), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c]  = '{period: 16'd2, width: 16'd1, mode: MODE_CONT};
            m_shd[c]  = '0;
            m_pend[c] = 1'b0;
            m_ph[c]   = PH_IDLE;
        end
        m_out  = '0;
        m_done = '0;
    endtask

    // Position in the current period (0..P), or idle / finished one-shot.
    task automatic model_step();
        pg_cfg_t nc;
        bit      wr;
        bit      last_os;
        if (!rst) begin
            model_reset();
            return;
        end
        nc = '{period: cfg_period, width: cfg_width,
               mode: cfg_oneshot ? MODE_ONESHOT : MODE_CONT};
        for (int c = 0; c < NCH; c++) begin
            wr        = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
            m_done[c] = 1'b0;
            if (!en[c]) begin
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
                if (wr) m_act[c] = nc;
                m_ph[c]  = PH_IDLE;
                m_out[c] = 1'b0;
            end else if (m_ph[c] == PH_FIN) begin
                if (wr) m_act[c] = nc;
                m_out[c] = 1'b0;
            end else if (m_ph[c] == PH_IDLE || m_ph[c] == int'(m_act[c].period)) begin
                last_os = (m_ph[c] != PH_IDLE) && (m_act[c].mode == MODE_ONESHOT);
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end else if (wr) begin
                    m_act[c] = nc;
                end
                if (last_os) begin
                    m_ph[c]   = PH_FIN;
                    m_out[c]  = 1'b0;
                    m_done[c] = 1'b1;
                end else begin
                    m_ph[c]  = 0;
                    m_out[c] = (m_act[c].width != 16'd0);
                end
            end else begin
                if (wr) begin
                    m_shd[c]  = nc;
                    m_pend[c] = 1'b1;
                end
                m_ph[c]++;
                m_out[c] = (m_ph[c] < int'(m_act[c].width));
            end
        end
    endtask

    task automatic check_cycle();
        chk("out", 32'(out), 32'(m_out));
        chk("done", 32'(done), 32'(m_done));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        check_cycle();
    endtask

    task automatic cfg_write(input int ch, input int p, input int w, input bit os);
        int n;
        cfg_ch      = 2'(ch);
        cfg_period  = 16'(p);
        cfg_width   = 16'(w);
        cfg_oneshot = os;
        cfg_valid   = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg_write_timeout: ready still 0 after %0d cycles, required 1", n);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [8:0]  s0, s1;
        logic [9:0]  s10;
        logic [11:0] so, sr, sd;
        logic [1:0]  s2;
        bit          acc;
        int          cnt, n;

        rst = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_width = '0; cfg_oneshot = 1'b0;
        model_reset();
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // 1: defaults, strobe 1 of every 3 starting right after enable
        en[0] = 1'b1;
        s0 = '0;
        for (int i = 0; i < 9; i++) begin tick(); s0 = {s0[7:0], out[0]}; end
        chk("t1_strobe", 32'(s0), 32'h124);

        // 2: ch1 P=9 W=4 continuous
        cfg_write(1, 9, 4, 1'b0);
        en[1] = 1'b1;
        cnt = 0; s10 = '0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i < 10) s10 = {s10[8:0], out[1]};
            if (out[1]) cnt++;
        end
        chk("t2_pattern", 32'(s10), 32'h3C0);
        chk("t2_duty", 32'(cnt), 32'd20);

        // 3: ch2 one-shot P=5 W=2
        cfg_write(2, 5, 2, 1'b1);
        en[2] = 1'b1;
        so = '0; sd = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            so = {so[10:0], out[2]};
            sd = {sd[10:0], done[2]};
        end
        chk("t3_out", 32'(so), 32'hC00);
        chk("t3_done", 32'(sd), 32'h020);
        repeat (5) tick();
        en[2] = 1'b0; tick();
        en[2] = 1'b1;
        s2 = '0;
        for (int i = 0; i < 2; i++) begin tick(); s2 = {s2[0], out[2]}; end
        chk("t3_rearm", 32'(s2), 32'h3);

        // 4: mid-period reconfig of ch0, second write held off while pending
        n = 0;
        while (!out[0] && n < 6) begin tick(); n++; end
        chk("t4_sync", 32'(out[0]), 32'h1);
        cfg_ch = 2'd0; cfg_period = 16'd7; cfg_width = 16'd3; cfg_oneshot = 1'b0;
        cfg_valid = 1'b1;
        chk("t4_ready_pre", 32'(cfg_ready), 32'h1);
        tick();
        cfg_period = 16'd4; cfg_width = 16'd2;
        so = '0; sr = '0;
        for (int i = 0; i < 12; i++) begin
            sr  = {sr[10:0], cfg_ready};
            acc = cfg_valid && cfg_ready;
            tick();
            if (acc) cfg_valid = 1'b0;
            so = {so[10:0], out[0]};
        end
        chk("t4_out", 32'(so), 32'h706);
        chk("t4_ready", 32'(sr), 32'h203);
        chk("t4_valid_dropped", 32'(cfg_valid), 32'h0);

        // 5: width edge cases on ch3
        cfg_write(3, 5, 0, 1'b0);
        en[3] = 1'b1; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (out[3]) cnt++; end
        chk("t5_w0", 32'(cnt), 32'd0);
        en[3] = 1'b0; tick();
        cfg_write(3, 5, 6, 1'b0);
        en[3] = 1'b1; cnt = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (out[3]) cnt++; end
        chk("t5_wfull", 32'(cnt), 32'd12);
        en[3] = 1'b0; tick();
        cfg_write(3, 0, 1, 1'b0);
        en[3] = 1'b1; cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (out[3]) cnt++; end
        chk("t5_p0", 32'(cnt), 32'd6);
        en[3] = 1'b0; tick();
        cfg_write(3, 0, 1, 1'b1);
        en[3] = 1'b1;
        so = '0; sd = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            so = {so[10:0], out[3]};
            sd = {sd[10:0], done[3]};
        end
        chk("t5_p0_os_out", 32'(so[2:0]), 32'h4);
        chk("t5_p0_os_done", 32'(sd[2:0]), 32'h2);

        // 6: async reset mid-period with a pending write on ch1
        n = 0;
        while (!out[1] && n < 12) begin tick(); n++; end
        chk("t6_sync", 32'(out[1]), 32'h1);
        cfg_ch = 2'd1; cfg_period = 16'd3; cfg_width = 16'd3; cfg_oneshot = 1'b0;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("t6_pending", 32'(cfg_ready), 32'h0);
        repeat (2) tick();
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_out", 32'(out), 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        chk("t6_rst_ready", 32'(cfg_ready), 32'h1);
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        s0 = '0; s1 = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            s0 = {s0[7:0], out[0]};
            s1 = {s1[7:0], out[1]};
        end
        chk("t6_ch0_default", 32'(s0), 32'h124);
        chk("t6_ch1_default", 32'(s1), 32'h124);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
